// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin owner arbiter driving the select of the shared datapath mux.
// A requester holds the grant from its grant edge until 'done'; 'sel' is stable for the whole
// ownership and keeps the last owner's index while idle.
// Optional watchdog: define MUX_ARB_TIMEOUT_EN to force a release after TIMEOUT cycles.
module mux_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SIGLEN  = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SIGLEN-1:0]  sel,
    output logic               busy,
    output logic               timeout
);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    localparam logic [NUM_REQ-1:0] OneHot0  = NUM_REQ'(1);
    localparam logic [SIGLEN-1:0]  LastInit = SIGLEN'(NUM_REQ - 1);

    state_e              state_q;
    logic [SIGLEN-1:0]   last_q;
    logic [SIGLEN-1:0]   winner;
    logic                any_req;
    logic                expire;
    logic                release_ev;

    // Find the first pending request after the previous owner; the previous owner goes last.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        any_req = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx = (int'(last_q) + k) % int'(NUM_REQ);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = SIGLEN'(idx);
            end
        end
    end

    assign release_ev = done | expire;

    // Ownership FSM with registered grant, select and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= LastInit;
            gnt     <= '0;
            sel     <= '0;
            busy    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q <= StOwn;
                        last_q  <= winner;
                        gnt     <= OneHot0 << winner;
                        sel     <= winner;
                        busy    <= 1'b1;
                    end
                end
                StOwn: begin
                    if (release_ev) begin
                        if (any_req) begin
                            last_q <= winner;
                            gnt    <= OneHot0 << winner;
                            sel    <= winner;
                        end else begin
                            // sel keeps the last owner so the mux output does not move
                            state_q <= StIdle;
                            gnt     <= '0;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q;

    assign expire = (state_q == StOwn) && !done && (cnt_q == CntW'(TIMEOUT - 1));

    // Watchdog: counts owned cycles without 'done', cleared on every grant or release edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
            if (state_q == StOwn && !release_ev) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule
